// File: rtl/fifo_dc_burst_wr.sv
// Burst-grouping write producer for the dual-clock FIFO: stages up to BURST_LEN
// words and commits each group as one back-to-back burst once space is free.
// Optional statistics counters: define FIFO_DC_BURST_WR_STAT_EN.
module fifo_dc_burst_wr #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 64,
  parameter int BURST_LEN  = 8,
  parameter int TIMEOUT    = 256
) (
  input  logic                          wr_clk_i,
  input  logic                          wr_rst_n_i,
  input  logic                          s_valid_i,
  input  logic [DATA_WIDTH-1:0]         s_data_i,
  input  logic                          s_last_i,
  output logic                          s_ready_o,
  output logic                          fifo_wr_en_o,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data_o,
  input  logic                          fifo_wr_full_i,
  input  logic [$clog2(FIFO_DEPTH):0]   fifo_wr_free_i,
  output logic                          busy_o,
  output logic [15:0]                   burst_cnt_o,
  output logic [15:0]                   stall_cnt_o
);

  localparam int CW = $clog2(BURST_LEN) + 1;
  localparam int IW = $clog2(BURST_LEN);
  localparam int FW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] IDLE_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {S_FILL, S_WAIT, S_DRAIN} state_t;

  state_t                state;
  logic [CW-1:0]         count;
  logic [IW-1:0]         idx;
  logic [TW-1:0]         idle;
  logic [DATA_WIDTH-1:0] stage_mem [BURST_LEN];

  logic accept;
  logic timeout_hit;
  logic last_write;

  // Handshake: a beat transfers on any edge where s_valid_i & s_ready_o; ready
  // depends only on state, and valid is never required to wait for ready.
  assign accept      = (state == S_FILL) & s_valid_i;
  assign timeout_hit = (TIMEOUT != 0) && (count != '0) && !accept && (idle == IDLE_LAST);
  assign last_write  = (state == S_DRAIN) & fifo_wr_en_o & ({1'b0, idx} == count - 1'b1);

  always_ff @(posedge wr_clk_i or negedge wr_rst_n_i) begin
    if (!wr_rst_n_i) begin
      state <= S_FILL;
      count <= '0;
      idx   <= '0;
      idle  <= '0;
    end else begin
      case (state)
        S_FILL: begin
          if (accept) begin
            count <= count + 1'b1;
            idle  <= '0;
            if (s_last_i || (count == CW'(BURST_LEN - 1))) state <= S_WAIT;
          end else if (count != '0) begin
            if (timeout_hit) state <= S_WAIT;
            if (idle != '1) idle <= idle + 1'b1;
          end
        end
        S_WAIT: begin
          // Free count is conservative, so committing only when it covers the
          // whole group guarantees the burst never overruns the FIFO.
          if (FW'(count) <= fifo_wr_free_i) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (fifo_wr_en_o) begin
            if (last_write) begin
              state <= S_FILL;
              count <= '0;
              idx   <= '0;
              idle  <= '0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: state <= S_FILL;
      endcase
    end
  end

  always_ff @(posedge wr_clk_i) begin
    if (accept) stage_mem[count[IW-1:0]] <= s_data_i;
  end

  assign s_ready_o      = (state == S_FILL);
  assign fifo_wr_en_o   = (state == S_DRAIN) & ~fifo_wr_full_i;
  assign fifo_wr_data_o = (state == S_DRAIN) ? stage_mem[idx] : '0;
  assign busy_o         = (count != '0) | (state != S_FILL);

`ifdef FIFO_DC_BURST_WR_STAT_EN
  logic [15:0] burst_cnt;
  logic [15:0] stall_cnt;

  always_ff @(posedge wr_clk_i or negedge wr_rst_n_i) begin
    if (!wr_rst_n_i) begin
      burst_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (last_write) burst_cnt <= burst_cnt + 16'd1;
      if (state == S_WAIT) stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign burst_cnt_o = burst_cnt;
  assign stall_cnt_o = stall_cnt;
`else
  assign burst_cnt_o = '0;
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_fifo_dc_burst_wr.sv
// Bench for fifo_dc_burst_wr: directed timing scenarios plus a randomized phase,
// with a queue-based scoreboard checking every FIFO write.
module tb_fifo_dc_burst_wr;

  localparam int DW  = 32;
  localparam int BL  = 8;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_last = 1'b0;
  logic          s_ready;
  logic          fifo_wr_en;
  logic [DW-1:0] fifo_wr_data;
  logic          fifo_wr_full = 1'b0;
  logic [6:0]    fifo_wr_free = 7'd64;
  logic          busy;
  logic [15:0]   burst_cnt;
  logic [15:0]   stall_cnt;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] exp_q[$];
  int            grp_q[$];
  int            grp_cnt = 0;
  int            burst_words = 0;
  bit            after_last = 1'b0;
  logic [6:0]    prev_free = '0;
  bit            rand_free = 1'b0;
  logic [6:0]    free_val = 7'd64;
  int            wr_seen = 0;

  fifo_dc_burst_wr #(
    .DATA_WIDTH(DW), .FIFO_DEPTH(64), .BURST_LEN(BL), .TIMEOUT(TMO)
  ) dut (
    .wr_clk_i(clk), .wr_rst_n_i(rst_n),
    .s_valid_i(s_valid), .s_data_i(s_data), .s_last_i(s_last), .s_ready_o(s_ready),
    .fifo_wr_en_o(fifo_wr_en), .fifo_wr_data_o(fifo_wr_data),
    .fifo_wr_full_i(fifo_wr_full), .fifo_wr_free_i(fifo_wr_free),
    .busy_o(busy), .burst_cnt_o(burst_cnt), .stall_cnt_o(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Free-space driver: either a fixed value or a fresh random level every cycle.
  always @(posedge clk) begin
    #1;
    if (rand_free) fifo_wr_free = 7'($urandom_range(0, 64));
    else fifo_wr_free = free_val;
  end

  // Monitor: every write is popped against the expected stream; group boundaries,
  // burst continuity, free-space respect and the post-burst ready are checked.
  always @(negedge clk) begin
    if (!rst_n) begin
      burst_words = 0;
      after_last = 1'b0;
    end else begin
      if (after_last) begin
        chk("ready_after_burst", {31'd0, s_ready}, 32'd1);
        chk("idle_after_burst", {31'd0, busy}, 32'd0);
        after_last = 1'b0;
      end
      if (fifo_wr_full) chk("en_while_full", {31'd0, fifo_wr_en}, 32'd0);
      if (fifo_wr_en) begin
        wr_seen++;
        chk("busy_in_drain", {31'd0, busy}, 32'd1);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: got data 0x%0h with empty expected queue", fifo_wr_data);
        end else begin
          chk("wr_data", fifo_wr_data, exp_q.pop_front());
        end
        if (burst_words == 0 && grp_q.size() > 0) begin
          checks++;
          if (int'(prev_free) < grp_q[0]) begin
            failures++;
            $display("FAIL free_respect: burst of %0d started with free %0d", grp_q[0], prev_free);
          end
        end
        burst_words++;
        if (grp_q.size() > 0 && burst_words == grp_q[0]) begin
          void'(grp_q.pop_front());
          burst_words = 0;
          after_last = 1'b1;
        end
      end else if (burst_words != 0) begin
        chk("burst_gap_without_full", {31'd0, fifo_wr_full}, 32'd1);
      end
    end
    prev_free = fifo_wr_free;
  end

  task automatic close_group();
    if (grp_cnt > 0) grp_q.push_back(grp_cnt);
    grp_cnt = 0;
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat is taken.
  task automatic send_beat(input logic [DW-1:0] d, input logic l);
    int waited = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    @(negedge clk);
    while (!s_ready && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (!s_ready) begin
      chk("accept_timeout", {31'd0, s_ready}, 32'd1);
    end else begin
      exp_q.push_back(d);
      grp_cnt++;
      if (l || grp_cnt == BL) close_group();
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk(name, exp_q.size(), 32'd0);
  endtask

  initial begin
    int n;
    int last_burst;
    #12;
    chk("rst_ready", {31'd0, s_ready}, 32'd1);
    chk("rst_wr_en", {31'd0, fifo_wr_en}, 32'd0);
    chk("rst_wr_data", fifo_wr_data, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_burst_cnt", {16'd0, burst_cnt}, 32'd0);
    chk("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full group of 8 with ample space: WAIT one cycle, then 8 writes.
    for (int i = 0; i < BL; i++) send_beat(DW'(i), 1'b0);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("t1_ready_low", {31'd0, s_ready}, 32'd0);
      chk("t1_wr_en", {31'd0, fifo_wr_en}, (i >= 1) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    chk("t1_ready_back", {31'd0, s_ready}, 32'd1);
`ifdef FIFO_DC_BURST_WR_STAT_EN
    chk("t1_burst_cnt", {16'd0, burst_cnt}, 32'd1);
`else
    chk("t1_burst_cnt_tied", {16'd0, burst_cnt}, 32'd0);
`endif
    @(posedge clk);
    #1;

    // Packet end closes a 3-word group; next beat follows right after.
    send_beat(32'hA, 1'b0);
    send_beat(32'hB, 1'b0);
    send_beat(32'hC, 1'b1);
    send_beat(32'h100, 1'b1);
    wait_drain("t2_drain");

    // Idle timeout flushes a 2-word group.
    send_beat(32'h21, 1'b0);
    send_beat(32'h22, 1'b0);
    n = 0;
    @(negedge clk);
    while (s_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("t3_timeout_cycles", n, TMO);
    close_group();
    wait_drain("t3_drain");

    // Insufficient free space holds the group in WAIT.
    free_val = 7'd5;
    @(posedge clk);
    #1;
    for (int i = 0; i < BL; i++) send_beat(32'h300 + DW'(i), 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("t4_no_write", {31'd0, fifo_wr_en}, 32'd0);
    end
`ifdef FIFO_DC_BURST_WR_STAT_EN
    checks++;
    if (stall_cnt < 16'd20) begin
      failures++;
      $display("FAIL t4_stall_cnt: got %0d expected at least 20", stall_cnt);
    end
`endif
    free_val = 7'd8;
    wait_drain("t4_drain");
    free_val = 7'd64;

    // Full pulse mid-drain after the 4th word.
    for (int i = 0; i < BL; i++) send_beat(32'h400 + DW'(i), 1'b0);
    wr_seen = 0;
    n = 0;
    while (wr_seen < 4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t5_reach_word4", wr_seen, 32'd4);
    @(posedge clk);
    #1 fifo_wr_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_paused", {31'd0, fifo_wr_en}, 32'd0);
    end
    @(posedge clk);
    #1 fifo_wr_full = 1'b0;
    wait_drain("t5_drain");
    chk("t5_total_writes", wr_seen, 32'd8);

    // Asynchronous reset during the third write of a burst.
    for (int i = 0; i < BL; i++) send_beat(32'h500 + DW'(i), 1'b0);
    wr_seen = 0;
    n = 0;
    while (wr_seen < 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_wr_en", {31'd0, fifo_wr_en}, 32'd0);
    chk("t6_rst_ready", {31'd0, s_ready}, 32'd1);
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    exp_q.delete();
    grp_q.delete();
    grp_cnt = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < BL; i++) send_beat(32'h600 + DW'(i), 1'b0);
    wait_drain("t6_drain");
`ifdef FIFO_DC_BURST_WR_STAT_EN
    chk("t6_burst_cnt", {16'd0, burst_cnt}, 32'd1);
`endif

    // Randomized stream with random packet ends, gaps and free-space levels.
    last_burst = 0;
    rand_free = 1'b1;
    for (int b = 0; b < 160; b++) begin
      send_beat(DW'($urandom), ($urandom_range(0, 6) == 0));
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
    end
    if (grp_cnt > 0) send_beat(32'hFEED, 1'b1);
    rand_free = 1'b0;
    free_val = 7'd64;
    wait_drain("rand_drain");
    chk("rand_groups_done", grp_q.size(), 32'd0);
    chk("rand_final_idle", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
